onehot_decoder_seq: RTL and testbench

Parametrised, registered binary-to-one-hot decoder with a valid/ready input handshake and three output modes: direct (hold), timed pulse and automatic scan. It succeeds the combinational 3-to-8 decoder. It sits between control logic and downstream select, strobe and chip-enable lines. Scan mode generates the full 0..OUT_W-1 walk in hardware, so stimulus and bring-up sequences need no external driver.

---
 rtl/decoder_pkg.sv | 39 +++
 rtl/dec_dwell_timer.sv | 46 ++++
 rtl/onehot_decoder_seq.sv | 169 ++++++++++++++++
 tb/tb_onehot_decoder_seq.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/decoder_pkg.sv
// -----------------------------------------------------------------------------
// decoder_pkg
// Shared types and helpers for the registered one-hot decoder.
//   mode_e  : command mode sampled when a request is accepted
//   state_e : controller states of onehot_decoder_seq
//   onehot  : binary code -> one-hot vector (all zeros when code >= width)
// -----------------------------------------------------------------------------
package decoder_pkg;

    typedef enum logic [1:0] {
        MODE_DIRECT = 2'b00,
        MODE_PULSE  = 2'b01,
        MODE_SCAN   = 2'b10,
        MODE_RSVD   = 2'b11
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_HOLD  = 2'd1,
        ST_PULSE = 2'd2,
        ST_SCAN  = 2'd3
    } state_e;

    // Widest one-hot vector the helper can produce; callers truncate.
    localparam int unsigned ONEHOT_MAX_W = 256;

    // An out-of-range code yields zero, which is exactly the output the
    // decoder must show for an illegal code.
    function automatic logic [ONEHOT_MAX_W-1:0] onehot(input int unsigned code,
                                                       input int unsigned width);
        logic [ONEHOT_MAX_W-1:0] v;
        v = '0;
        if (code < width && code < ONEHOT_MAX_W) begin
            v = ONEHOT_MAX_W'(1) << code;
        end
        return v;
    endfunction

endpackage

// File: rtl/dec_dwell_timer.sv
// -----------------------------------------------------------------------------
// dec_dwell_timer
// Load / count-down timer that flags the last cycle of a DWELL-cycle window.
//   clk    in  clock
//   rst    in  synchronous active-high reset
//   clear  in  abort: counter to zero, no expire
//   load   in  start a new window of DWELL cycles (next cycle is cycle 1)
//   expire out high during the final cycle of the window
// -----------------------------------------------------------------------------
module dec_dwell_timer #(
    parameter int DWELL = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic load,
    output logic expire
);

    localparam int CNT_W = $clog2(DWELL + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (load) begin
            cnt_d = CNT_W'(DWELL);
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Counter holds DWELL in the first window cycle, so 1 marks the last one.
    assign expire = (cnt_q == CNT_W'(1));

endmodule

// File: rtl/onehot_decoder_seq.sv
// -----------------------------------------------------------------------------
// onehot_decoder_seq
// Registered binary-to-one-hot decoder with valid/ready input and three
// output modes: DIRECT (hold), PULSE (DWELL cycles) and SCAN (walk of all
// OUT_W bits, DWELL cycles each).
//   clk       in   clock
//   rst       in   synchronous active-high reset
//   en        in   global enable; low forces IDLE and zero output
//   mode      in   00 DIRECT, 01 PULSE, 10 SCAN, 11 reserved (acts as DIRECT)
//   in_valid  in   request present
//   in_ready  out  request can be accepted (IDLE or HOLD, en high)
//   datain    in   binary code (ignored for SCAN)
//   dataout   out  registered one-hot value or zero
//   out_valid out  dataout carries a decoded value
//   busy      out  PULSE or SCAN in progress
//   done      out  one-cycle pulse after a PULSE/SCAN completes normally
//   err       out  sticky out-of-range flag, only with DECODER_RANGE_CHK_EN
// Optional feature macro: DECODER_RANGE_CHK_EN
// -----------------------------------------------------------------------------
module onehot_decoder_seq
    import decoder_pkg::*;
#(
    parameter int IN_W  = 3,
    parameter int OUT_W = 8,
    parameter int DWELL = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  datain,
    output logic [OUT_W-1:0] dataout,
    output logic             out_valid,
    output logic             busy,
    output logic             done
`ifdef DECODER_RANGE_CHK_EN
    ,
    output logic             err
`endif
);

    localparam int IDX_W = (OUT_W > 1) ? $clog2(OUT_W) : 1;

    state_e            state_q, state_d;
    logic [OUT_W-1:0]  dataout_q, dataout_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic              done_q, done_d;
    logic              timer_load;
    logic              timer_expire;
    logic              accept;

    dec_dwell_timer #(.DWELL(DWELL)) u_timer (
        .clk    (clk),
        .rst    (rst),
        .clear  (!en),
        .load   (timer_load),
        .expire (timer_expire)
    );

    assign in_ready = en && (state_q == ST_IDLE || state_q == ST_HOLD);
    assign accept   = in_valid && in_ready;

    // NOTE: every signal driven here gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        state_d    = state_q;
        dataout_d  = dataout_q;
        idx_d      = idx_q;
        done_d     = 1'b0;
        timer_load = 1'b0;

        if (!en) begin
            // Abort anything in flight; no done pulse.
            state_d   = ST_IDLE;
            dataout_d = '0;
            idx_d     = '0;
        end else if (accept) begin
            case (mode_e'(mode))
                MODE_SCAN: begin
                    state_d    = ST_SCAN;
                    idx_d      = '0;
                    dataout_d  = OUT_W'(onehot(32'd0, OUT_W));
                    timer_load = 1'b1;
                end
                MODE_PULSE: begin
                    state_d    = ST_PULSE;
                    dataout_d  = OUT_W'(onehot(32'(datain), OUT_W));
                    timer_load = 1'b1;
                end
                default: begin
                    // DIRECT and the reserved encoding both hold the value.
                    state_d   = ST_HOLD;
                    dataout_d = OUT_W'(onehot(32'(datain), OUT_W));
                end
            endcase
        end else begin
            case (state_q)
                ST_PULSE: begin
                    if (timer_expire) begin
                        state_d   = ST_IDLE;
                        dataout_d = '0;
                        done_d    = 1'b1;
                    end
                end
                ST_SCAN: begin
                    if (timer_expire) begin
                        if (idx_q == IDX_W'(OUT_W - 1)) begin
                            state_d   = ST_IDLE;
                            dataout_d = '0;
                            done_d    = 1'b1;
                        end else begin
                            idx_d      = idx_q + IDX_W'(1);
                            dataout_d  = OUT_W'(onehot(32'(idx_q) + 32'd1, OUT_W));
                            timer_load = 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            dataout_q <= '0;
            idx_q     <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            dataout_q <= dataout_d;
            idx_q     <= idx_d;
            done_q    <= done_d;
        end
    end

    assign dataout   = dataout_q;
    // An out-of-range code decodes to zero, so a non-zero output is valid.
    assign out_valid = |dataout_q;
    assign busy      = (state_q == ST_PULSE) || (state_q == ST_SCAN);
    assign done      = done_q;

`ifdef DECODER_RANGE_CHK_EN
    logic code_oor;
    logic err_q;

    // With a full code space every code is legal.
    if (OUT_W == (1 << IN_W)) begin : g_full_range
        assign code_oor = 1'b0;
    end else begin : g_part_range
        assign code_oor = (32'(datain) >= 32'(OUT_W));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (en && accept && code_oor && mode_e'(mode) != MODE_SCAN) begin
            err_q <= 1'b1;
        end
    end

    assign err = err_q;
`endif

endmodule

// File: tb/tb_onehot_decoder_seq.sv
// -----------------------------------------------------------------------------
// tb_onehot_decoder_seq
// Randomized bench for onehot_decoder_seq. The reference model plans the
// whole output sequence of a PULSE or SCAN as a queue of values at accept
// time and pops one per cycle; DIRECT just holds a value.
// OUT_W is 6 with a 3-bit code so that codes 6 and 7 are out of range.
// -----------------------------------------------------------------------------
module tb_onehot_decoder_seq;

    localparam int IN_W  = 3;
    localparam int OUT_W = 6;
    localparam int DWELL = 3;
    localparam int N_CYC = 3000;

    logic             clk = 1'b0;
    logic             rst;
    logic             en;
    logic [1:0]       mode;
    logic             in_valid;
    logic             in_ready;
    logic [IN_W-1:0]  datain;
    logic [OUT_W-1:0] dataout;
    logic             out_valid;
    logic             busy;
    logic             done;
`ifdef DECODER_RANGE_CHK_EN
    logic             err;
`endif

    always #5 clk = ~clk;

    onehot_decoder_seq #(
        .IN_W  (IN_W),
        .OUT_W (OUT_W),
        .DWELL (DWELL)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .mode      (mode),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .datain    (datain),
        .dataout   (dataout),
        .out_valid (out_valid),
        .busy      (busy),
        .done      (done)
`ifdef DECODER_RANGE_CHK_EN
        ,
        .err       (err)
`endif
    );

    int n_vec = 0;
    int n_miscompare = 0;

    // Reference model state.
    logic [OUT_W-1:0] plan[$];
    logic             holding;
    logic [OUT_W-1:0] hold_val;
    logic             m_done;
    logic             m_err;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miscompare++;
            $display("FAIL %s at %0t: got %0h, expected %0h", tag, $time, got, exp);
        end
    endtask

    function automatic logic [OUT_W-1:0] code_to_onehot(input int code);
        if (code < OUT_W) return OUT_W'(1) << code;
        return '0;
    endfunction

    function automatic logic [OUT_W-1:0] model_dataout();
        if (plan.size() > 0) return plan[0];
        if (holding) return hold_val;
        return '0;
    endfunction

    // Advance the model by one rising edge with the inputs sampled there.
    task automatic model_step(input logic r, input logic e, input logic v,
                              input logic [1:0] m, input logic [IN_W-1:0] d);
        logic rdy;
        rdy    = e && (plan.size() == 0);
        m_done = 1'b0;
        if (r) begin
            plan.delete();
            holding  = 1'b0;
            hold_val = '0;
            m_err    = 1'b0;
        end else if (!e) begin
            plan.delete();
            holding = 1'b0;
        end else if (v && rdy) begin
            holding = 1'b0;
            if (m == 2'b10) begin
                for (int i = 0; i < OUT_W; i++)
                    for (int j = 0; j < DWELL; j++)
                        plan.push_back(OUT_W'(1) << i);
            end else if (m == 2'b01) begin
                for (int j = 0; j < DWELL; j++)
                    plan.push_back(code_to_onehot(int'(d)));
            end else begin
                holding  = 1'b1;
                hold_val = code_to_onehot(int'(d));
            end
            if (m != 2'b10 && int'(d) >= OUT_W) m_err = 1'b1;
        end else if (plan.size() > 0) begin
            void'(plan.pop_front());
            if (plan.size() == 0) m_done = 1'b1;
        end
    endtask

    initial begin
        logic [OUT_W-1:0] exp_out;
        plan.delete();
        holding  = 1'b0;
        hold_val = '0;
        m_done   = 1'b0;
        m_err    = 1'b0;

        rst      = 1'b1;
        en       = 1'b0;
        mode     = 2'b00;
        in_valid = 1'b0;
        datain   = '0;

        for (int cyc = 0; cyc < N_CYC; cyc++) begin
            @(posedge clk);
            model_step(rst, en, in_valid, mode, datain);

            @(negedge clk);
            exp_out = model_dataout();
            check("dataout",   32'(dataout),   32'(exp_out));
            check("out_valid", 32'(out_valid), 32'(exp_out != '0));
            check("busy",      32'(busy),      32'(plan.size() > 0));
            check("done",      32'(done),      32'(m_done));
`ifdef DECODER_RANGE_CHK_EN
            check("err",       32'(err),       32'(m_err));
`endif

            // New inputs for the next edge.
            rst      = (cyc < 2) || ($urandom_range(0, 399) == 0);
            en       = (cyc < 2) ? 1'b1 : ($urandom_range(0, 59) != 0);
            in_valid = ($urandom_range(0, 2) != 0);
            mode     = 2'($urandom_range(0, 3));
            datain   = IN_W'($urandom_range(0, (1 << IN_W) - 1));
            #1;
            check("in_ready", 32'(in_ready), 32'(en && plan.size() == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscompare);
        $finish;
    end

endmodule
